// File: rtl/ac_core.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator machine.
// Masters the 32x8 RAM directly; its read data is combinational, so there are no wait states.
module ac_core #(
  parameter int AW = 5,
  parameter int DW = 8,
  parameter logic [AW-1:0] PC_RST = '0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic [DW-1:0] mem_dout_i,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_wen_o,
  output logic [DW-1:0] mem_din_o,
  output logic [DW-1:0] acc_o,
  output logic [AW-1:0] pc_o,
  output logic [DW-1:0] ir_o,
  output logic          zero_o,
  output logic          carry_o,
  output logic          halted_o
);

  typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_JMP   = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_NOP   = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  state_t        r_state;
  state_t        w_stateNext;
  logic [AW-1:0] r_pc;
  logic [DW-1:0] r_ir;
  logic [DW-1:0] r_acc;
  logic          r_z;
  logic          r_c;
  logic [2:0]    w_opcode;
  logic [AW-1:0] w_operand;
  logic [DW:0]   w_sum;
  logic [DW:0]   w_diff;
  logic          w_wen;
  logic [AW-1:0] w_addr;

  assign w_opcode  = r_ir[DW-1:DW-3];
  assign w_operand = r_ir[AW-1:0];
  // The ninth bit of the difference is the borrow, i.e. ACC < operand
  assign w_sum     = {1'b0, r_acc} + {1'b0, mem_dout_i};
  assign w_diff    = {1'b0, r_acc} - {1'b0, mem_dout_i};

  always_comb begin
    w_stateNext = r_state;
    w_wen       = 1'b0;
    w_addr      = w_operand;
    case (r_state)
      FETCH: begin
        w_addr      = r_pc;
        w_stateNext = DECODE;
      end
      DECODE: begin
        case (w_opcode)
          OP_LOAD, OP_ADD, OP_SUB: w_stateNext = EXEC;
          OP_STORE: begin
            w_wen       = en_i;
            w_stateNext = FETCH;
          end
          OP_HALT:                 w_stateNext = HALT;
          default:                 w_stateNext = FETCH;
        endcase
      end
      EXEC:    w_stateNext = FETCH;
      HALT:    w_stateNext = HALT;
      default: w_stateNext = FETCH;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= FETCH;
      r_pc    <= PC_RST;
      r_ir    <= '0;
      r_acc   <= '0;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
    end else if (en_i) begin
      r_state <= w_stateNext;
      case (r_state)
        FETCH: begin
          r_ir <= mem_dout_i;
          r_pc <= r_pc + 1'b1;
        end
        DECODE: begin
          if (w_opcode == OP_JMP || (w_opcode == OP_JZ && r_z)) begin
            r_pc <= w_operand;
          end
        end
        EXEC: begin
          case (w_opcode)
            OP_LOAD: begin
              r_acc <= mem_dout_i;
              r_z   <= (mem_dout_i == '0);
            end
            OP_ADD: begin
              r_acc <= w_sum[DW-1:0];
              r_c   <= w_sum[DW];
              r_z   <= (w_sum[DW-1:0] == '0);
            end
            OP_SUB: begin
              r_acc <= w_diff[DW-1:0];
              r_c   <= w_diff[DW];
              r_z   <= (w_diff[DW-1:0] == '0);
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign mem_addr_o = w_addr;
  assign mem_wen_o  = w_wen;
  assign mem_din_o  = r_acc;
  assign acc_o      = r_acc;
  assign pc_o       = r_pc;
  assign ir_o       = r_ir;
  assign zero_o     = r_z;
  assign carry_o    = r_c;
  assign halted_o   = (r_state == HALT);

endmodule

// File: tb/tb_ac_core.sv
// Self-checking bench for ac_core: directed programs plus random programs
// checked instruction-by-instruction against an ISA-level model.
module tb_ac_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] memDout;
  logic [4:0] memAddr;
  logic       memWen;
  logic [7:0] memDin;
  logic [7:0] acc;
  logic [4:0] pc;
  logic [7:0] ir;
  logic       zero;
  logic       carry;
  logic       halted;

  logic [7:0] ram [32];
  logic [7:0] image [32];
  logic       loadReq = 1'b0;
  int         wrCount = 0;

  int         nChecks = 0;
  int         nFails  = 0;

  // ISA-level reference state
  logic [7:0] mm [32];
  int         mPc;
  int         mAcc;
  bit         mZ;
  bit         mC;
  bit         mHalted;

  ac_core dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (enable),
    .mem_dout_i (memDout),
    .mem_addr_o (memAddr),
    .mem_wen_o  (memWen),
    .mem_din_o  (memDin),
    .acc_o      (acc),
    .pc_o       (pc),
    .ir_o       (ir),
    .zero_o     (zero),
    .carry_o    (carry),
    .halted_o   (halted)
  );

  always #5 clk = ~clk;

  // RAM: bulk preload from the image on request, otherwise a synchronous write port
  always @(posedge clk) begin
    if (loadReq) begin
      for (int i = 0; i < 32; i++) ram[i] <= image[i];
    end else if (memWen) begin
      ram[memAddr] <= memDin;
      wrCount      <= wrCount + 1;
    end
  end

  assign memDout = ram[memAddr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearImage();
    for (int i = 0; i < 32; i++) image[i] = 8'h00;
  endtask

  // Hold reset, preload RAM, optionally check reset values, then release reset
  task automatic startProgram(input bit checkReset);
    rst_n   = 1'b0;
    enable  = 1'b1;
    loadReq = 1'b1;
    tick();
    loadReq = 1'b0;
    tick();
    if (checkReset) begin
      checkOutput("rstPc", pc, 0);
      checkOutput("rstAcc", acc, 0);
      checkOutput("rstIr", ir, 0);
      checkOutput("rstZ", zero, 0);
      checkOutput("rstC", carry, 0);
      checkOutput("rstHalted", halted, 0);
      checkOutput("rstWen", memWen, 0);
      checkOutput("rstAddr", memAddr, 0);
      checkOutput("rstDin", memDin, 0);
    end
    for (int i = 0; i < 32; i++) mm[i] = image[i];
    mPc = 0; mAcc = 0; mZ = 0; mC = 0; mHalted = 0;
    rst_n = 1'b1;
  endtask

  // Execute one instruction on the model; returns how many clocks the core should take
  task automatic modelStep(output int cyc);
    int iw, a, opnd, sum;
    iw   = int'(mm[mPc]);
    mPc  = (mPc + 1) % 32;
    a    = iw % 32;
    opnd = int'(mm[a]);
    cyc  = 2;
    case (iw / 32)
      0: begin mAcc = opnd; mZ = (mAcc == 0); cyc = 3; end
      1: mm[a] = 8'(mAcc);
      2: begin sum = mAcc + opnd; mC = (sum > 255); mAcc = sum % 256; mZ = (mAcc == 0); cyc = 3; end
      3: begin mC = (mAcc < opnd); mAcc = (mAcc + 256 - opnd) % 256; mZ = (mAcc == 0); cyc = 3; end
      4: mPc = a;
      5: if (mZ) mPc = a;
      6: ;
      default: mHalted = 1;
    endcase
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, ".pc"}, pc, mPc);
    checkOutput({tag, ".acc"}, acc, mAcc);
    checkOutput({tag, ".z"}, zero, mZ);
    checkOutput({tag, ".c"}, carry, mC);
    checkOutput({tag, ".halted"}, halted, mHalted);
    checkOutput({tag, ".din"}, memDin, mAcc);
  endtask

  task automatic checkRam(input string tag);
    for (int i = 0; i < 32; i++) checkOutput($sformatf("%s.ram[%0d]", tag, i), ram[i], mm[i]);
  endtask

  // Run up to n instructions, optionally with random idle freezes between them
  task automatic applyStimulus(input int n, input bit randFreeze, input string tag);
    int cyc;
    for (int k = 0; k < n && !mHalted; k++) begin
      if (randFreeze && $urandom_range(3) == 0) begin
        enable = 1'b0;
        repeat ($urandom_range(3, 1)) tick();
        checkOutput({tag, ".frozenWen"}, memWen, 0);
        checkState({tag, ".frozen"});
        enable = 1'b1;
      end
      modelStep(cyc);
      repeat (cyc) tick();
      checkState(tag);
    end
    if (mHalted) begin
      repeat (3) tick();
      checkState({tag, ".stayHalted"});
    end
  endtask

  initial begin
    int wrSnap;
    int cyc;
    rst_n  = 1'b0;
    enable = 1'b0;

    // Arithmetic program with exact cycle timing of the store and the halt
    clearImage();
    image[0] = 8'h1D; image[1] = 8'h5E; image[2] = 8'h3F; image[3] = 8'hE0;
    image[29] = 8'd3; image[30] = 8'd2;
    startProgram(1);
    wrSnap = wrCount;
    for (int k = 1; k <= 12; k++) begin
      checkOutput($sformatf("arith.wen@%0d", k), memWen, (k == 8));
      checkOutput($sformatf("arith.halted@%0d", k), halted, (k > 10));
      tick();
    end
    checkOutput("arith.acc", acc, 5);
    checkOutput("arith.z", zero, 0);
    checkOutput("arith.c", carry, 0);
    checkOutput("arith.pc", pc, 4);
    checkOutput("arith.ram31", ram[31], 5);
    checkOutput("arith.writes", wrCount - wrSnap, 1);

    // SUB with borrow
    clearImage();
    image[0] = 8'h1E; image[1] = 8'h7D; image[2] = 8'hE0;
    image[29] = 8'd3; image[30] = 8'd2;
    startProgram(0);
    applyStimulus(10, 0, "sub");
    checkOutput("sub.acc", acc, 8'hFF);
    checkOutput("sub.c", carry, 1);
    checkOutput("sub.z", zero, 0);

    // ADD carry to zero, JZ taken
    clearImage();
    image[0] = 8'h1D; image[1] = 8'h5E; image[2] = 8'hAA; image[3] = 8'hE0; image[10] = 8'hE0;
    image[29] = 8'hFF; image[30] = 8'h01;
    startProgram(0);
    applyStimulus(3, 0, "jzT");
    checkOutput("jzT.pcAfterJz", pc, 10);
    checkOutput("jzT.acc", acc, 0);
    checkOutput("jzT.c", carry, 1);
    checkOutput("jzT.z", zero, 1);
    applyStimulus(5, 0, "jzT");
    checkOutput("jzT.halted", halted, 1);

    // Same program, nonzero sum: JZ not taken
    image[30] = 8'h02;
    startProgram(0);
    applyStimulus(3, 0, "jzN");
    checkOutput("jzN.pcAfterJz", pc, 3);
    checkOutput("jzN.acc", acc, 1);
    applyStimulus(5, 0, "jzN");
    checkOutput("jzN.halted", halted, 1);

    // PC wrap: plant HALT at 0, jump to 31 (NOP), fall through to 0
    clearImage();
    image[0] = 8'h04; image[1] = 8'h20; image[2] = 8'h9F; image[4] = 8'hE0; image[31] = 8'hC0;
    startProgram(0);
    applyStimulus(3, 0, "wrap");
    checkOutput("wrap.pcAt31", pc, 31);
    applyStimulus(1, 0, "wrap");
    checkOutput("wrap.pcWrapped", pc, 0);
    applyStimulus(5, 0, "wrap");
    checkOutput("wrap.halted", halted, 1);
    checkRam("wrap");

    // Freeze a STORE in DECODE for five cycles
    clearImage();
    image[0] = 8'h1D; image[1] = 8'h34; image[2] = 8'hE0; image[29] = 8'h5A;
    startProgram(0);
    applyStimulus(1, 0, "frz");
    modelStep(cyc);
    tick();
    checkOutput("frz.wenDecode", memWen, 1);
    wrSnap = wrCount;
    enable = 1'b0;
    #1;
    checkOutput("frz.wenForced", memWen, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("frz.wen", memWen, 0);
      checkOutput("frz.pc", pc, 2);
      checkOutput("frz.ir", ir, 8'h34);
      checkOutput("frz.acc", acc, 8'h5A);
      checkOutput("frz.halted", halted, 0);
      checkOutput("frz.ramHeld", ram[20], 0);
    end
    enable = 1'b1;
    tick();
    checkOutput("frz.ramWritten", ram[20], 8'h5A);
    checkState("frz.resume");
    applyStimulus(5, 0, "frz");
    checkOutput("frz.writes", wrCount - wrSnap, 1);
    checkRam("frz");

    // Asynchronous reset in the middle of a STORE decode cycle
    clearImage();
    image[0] = 8'h1D; image[1] = 8'h34; image[2] = 8'hE0; image[29] = 8'h77;
    startProgram(0);
    applyStimulus(1, 0, "ares");
    tick();
    checkOutput("ares.wenBefore", memWen, 1);
    wrSnap = wrCount;
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("ares.wen", memWen, 0);
    checkOutput("ares.pc", pc, 0);
    checkOutput("ares.acc", acc, 0);
    repeat (2) tick();
    checkOutput("ares.ram", ram[20], 0);
    checkOutput("ares.writes", wrCount - wrSnap, 0);
    rst_n = 1'b1;
    checkOutput("ares.addr", memAddr, 0);
    tick();
    checkOutput("ares.ir", ir, 8'h1D);
    checkOutput("ares.pcAfter", pc, 1);

    // Random programs against the ISA model, with random freezes
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 32; i++) image[i] = 8'($urandom_range(255));
      startProgram(0);
      applyStimulus(40, 1, $sformatf("rand%0d", p));
      checkRam($sformatf("rand%0d", p));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
